// File: rtl/idi_stream_arbiter.sv
// rtl/idi_stream_arbiter.sv - packet-granular round-robin arbiter merging N IDI source streams onto one bus
module idi_stream_arbiter #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int GAP    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        s_valid,
    input  logic [N-1:0]        s_sop,
    input  logic [N-1:0]        s_eop,
    input  logic [6*N-1:0]      s_dt,
    input  logic [2*N-1:0]      s_vc,
    input  logic [16*N-1:0]     s_wc,
    input  logic [DATA_W*N-1:0] s_data,
    output logic [N-1:0]        s_ready,
    output logic                m_valid,
    output logic                m_sop,
    output logic                m_eop,
    output logic [5:0]          m_dt,
    output logic [1:0]          m_vc,
    output logic [15:0]         m_wc,
    output logic [DATA_W-1:0]   m_data,
    input  logic                m_ready,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                busy,
    output logic                len_err
);

    localparam int GW    = $clog2(N);
    localparam int BYTES = DATA_W / 8;
    localparam logic [GW:0] N_W      = (GW + 1)'(N);
    localparam logic [7:0]  GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [GW-1:0] rr_q, rr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [7:0]    gap_q, gap_d;
    logic [15:0]   beat_q, beat_d;
    logic [15:0]   exp_q, exp_d;
    logic          len_err_q, len_err_d;

    logic              g_valid, g_sop, g_eop;
    logic [5:0]        g_dt;
    logic [1:0]        g_vc;
    logic [15:0]       g_wc;
    logic [DATA_W-1:0] g_data;

    logic [N-1:0]   elig, rot;
    logic [2*N-1:0] elig2;
    logic [GW-1:0]  off, sel;
    logic [GW:0]    sel_sum, nxt_sum;
    logic           found, hs;
    logic [15:0]    cnt_inc, exp_now;

    // Short packets (dt < 0x10) carry a frame/line number in wc, so they always expect one beat.
    function automatic logic [15:0] expected_beats(input logic [5:0] dt, input logic [15:0] wc);
        logic [16:0] rounded;
        rounded = {1'b0, wc} + 17'(BYTES - 1);
        if (dt < 6'h10 || wc == 16'd0) return 16'd1;
        return 16'(rounded / 17'(BYTES));
    endfunction

    always_comb begin
        g_valid = 1'b0;
        g_sop   = 1'b0;
        g_eop   = 1'b0;
        g_dt    = '0;
        g_vc    = '0;
        g_wc    = '0;
        g_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_q == GW'(k)) begin
                g_valid = s_valid[k];
                g_sop   = s_sop[k];
                g_eop   = s_eop[k];
                g_dt    = s_dt[6*k +: 6];
                g_vc    = s_vc[2*k +: 2];
                g_wc    = s_wc[16*k +: 16];
                g_data  = s_data[DATA_W*k +: DATA_W];
            end
        end
    end

    assign m_valid = ~rst & (state_q == ST_XFER) & g_valid;
    assign m_sop   = m_valid & g_sop;
    assign m_eop   = m_valid & g_eop;
    assign m_dt    = g_dt;
    assign m_vc    = g_vc;
    assign m_wc    = g_wc;
    assign m_data  = g_data;
    assign hs      = m_valid & m_ready;

    // In IDLE only stray (non-SOP) beats are accepted so that they drain instead of blocking.
    always_comb begin
        s_ready = '0;
        if (!rst) begin
            if (state_q == ST_IDLE) begin
                s_ready = s_valid & ~s_sop;
            end else if (state_q == ST_XFER) begin
                for (int k = 0; k < N; k++) begin
                    s_ready[k] = (grant_q == GW'(k)) & m_ready;
                end
            end
        end
    end

    // Rotate the request vector so the search starts at rr_q, then take the lowest set bit.
    always_comb begin
        elig  = s_valid & s_sop;
        elig2 = {elig, elig} >> rr_q;
        rot   = elig2[N-1:0];
        found = |rot;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = GW'(k);
        end
        sel_sum = {1'b0, rr_q} + {1'b0, off};
        if (sel_sum >= N_W) sel_sum = sel_sum - N_W;
        sel     = sel_sum[GW-1:0];
        nxt_sum = {1'b0, grant_q} + {{GW{1'b0}}, 1'b1};
        if (nxt_sum >= N_W) nxt_sum = '0;
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        gap_d     = gap_q;
        beat_d    = beat_q;
        exp_d     = exp_q;
        len_err_d = 1'b0;
        cnt_inc   = (beat_q == 16'hFFFF) ? beat_q : beat_q + 16'd1;
        exp_now   = (beat_q == 16'd0) ? expected_beats(g_dt, g_wc) : exp_q;
        case (state_q)
            ST_IDLE: begin
                if (|(s_valid & ~s_sop)) len_err_d = 1'b1;
                if (found) begin
                    grant_d = sel;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (hs) begin
                    if (beat_q == 16'd0) exp_d = exp_now;
                    if (beat_q != 16'd0 && g_sop) len_err_d = 1'b1;
                    if (g_eop) begin
                        if (beat_q == 16'hFFFF || cnt_inc != exp_now) len_err_d = 1'b1;
                        beat_d = '0;
                        rr_d   = nxt_sum[GW-1:0];
                        if (GAP > 0) begin
                            state_d = ST_GAP;
                            gap_d   = GAP_LOAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        beat_d = cnt_inc;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 8'd0) state_d = ST_IDLE;
                else gap_d = gap_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            gap_q     <= '0;
            beat_q    <= '0;
            exp_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            gap_q     <= gap_d;
            beat_q    <= beat_d;
            exp_q     <= exp_d;
            len_err_q <= len_err_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign len_err  = len_err_q;

endmodule
